// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
//
// Both sides use valid/ready: a transfer happens on a rising clk edge
// exactly when valid and ready are both high in that cycle. The
// producer holds its data stable while valid is high and not yet
// accepted. Ready may depend on internal state only, never on valid.
// flush and count travel with the bundle because the queue's
// consumer side (the pipeline control) drives or watches them.
interface if_id_queue_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;

  // Pipeline side: fetch + decode + control driving the queue.
  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: small FIFO of {pc, instr} pairs between fetch
// and decode. in_ready doubles as the fetch PC-write enable, so a full
// queue stalls fetch. A flush (branch/jump redirect) empties it.
// An empty queue presents pc=0 / instr=0 so decode sees a nop.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  if_id_queue_if.slave  q
);

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic [63:0]   rd_entry;

  assign in_ready  = (cnt_q != CNT_FULL);
  assign out_valid = (cnt_q != '0);
  assign push      = q.in_valid & in_ready;
  assign pop       = out_valid & q.out_ready;
  assign rd_entry  = mem_q[rp_q];

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.count     = cnt_q;
  // Empty queue shows a nop rather than a stale entry.
  assign q.out_pc    = out_valid ? rd_entry[63:32] : 32'h0000_0000;
  assign q.out_instr = out_valid ? rd_entry[31:0]  : 32'h0000_0000;

  // Next-state for pointers and occupancy; flush discards the cycle's push/pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (q.flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_ONE;
      if (pop)  rp_d = rp_q + PTR_ONE;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Pointer/occupancy registers; reset behaves like a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents need no reset since cnt gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && !q.flush && push) begin
      mem_q[wp_q] <= {q.in_pc, q.in_instr};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a driver steps one cycle per call and
// records accepted pairs in exp_q; a negedge monitor checks status against
// that queue and pops/compares each entry decode consumes.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic reset;
  logic mon_en;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];

  if_id_queue_if #(.AW(AW)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, called at posedge+1; model updated at the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                      input logic ordy, input logic fl, input logic rst);
    logic acc;
    acc = v && !fl && !rst && (exp_q.size() != DEPTH);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    bus.flush     = fl;
    reset         = rst;
    @(posedge clk);
    if (rst || fl) exp_q.delete();
    else if (acc) exp_q.push_back({pc, instr});
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic idle_pop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_out_valid", {63'b0, bus.out_valid}, {63'b0, exp_q.size() != 0});
      check("mon_in_ready", {63'b0, bus.in_ready}, {63'b0, exp_q.size() != DEPTH});
      check("mon_count", 64'(bus.count), 64'(exp_q.size()));
      if (exp_q.size() == 0) begin
        check("mon_empty_nop", {bus.out_pc, bus.out_instr}, 64'h0);
      end else if (bus.out_valid && bus.out_ready) begin
        check("mon_pop_data", {bus.out_pc, bus.out_instr}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    reset  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 32'h0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    check("rst_out_valid", {63'b0, bus.out_valid}, 64'h0);
    check("rst_out_pc", {32'b0, bus.out_pc}, 64'h0);
    check("rst_out_instr", {32'b0, bus.out_instr}, 64'h0);
    check("rst_in_ready", {63'b0, bus.in_ready}, 64'h1);
    check("rst_count", 64'(bus.count), 64'h0);

    // Single push, visible only after the edge.
    step(1'b1, 32'h3000, 32'h2408_0001, 1'b0, 1'b0, 1'b0);
    check("one_out_valid", {63'b0, bus.out_valid}, 64'h1);
    check("one_out_pc", {32'b0, bus.out_pc}, 64'h3000);
    check("one_out_instr", {32'b0, bus.out_instr}, 64'h2408_0001);
    check("one_count", 64'(bus.count), 64'h1);
    idle_pop(1);
    check("one_drained", 64'(bus.count), 64'h0);

    // Fill to full, then a 5th push with out_ready=1 is refused.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h3000 + 32'(4 * i), 32'h2408_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("full_count", 64'(bus.count), 64'h4);
    check("full_in_ready", {63'b0, bus.in_ready}, 64'h0);
    step(1'b1, 32'h3010, 32'h2408_0004, 1'b1, 1'b0, 1'b0);
    check("after_full_in_ready", {63'b0, bus.in_ready}, 64'h1);
    check("after_full_out_pc", {32'b0, bus.out_pc}, 64'h3004);
    check("after_full_count", 64'(bus.count), 64'h3);
    idle_pop(3);
    check("full_drained", 64'(bus.count), 64'h0);

    // Streaming push+pop across pointer wrap; occupancy holds at 1.
    step(1'b1, 32'h3000, 32'h1000_0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
      check("stream_count", 64'(bus.count), 64'h1);
      check("stream_out_pc", {32'b0, bus.out_pc}, 64'(32'h3000 + 32'(4 * i)));
    end
    idle_pop(1);

    // Flush with concurrent push and pop discards everything.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h3040 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3050, 32'h2000_0003, 1'b1, 1'b1, 1'b0);
    check("flush_count", 64'(bus.count), 64'h0);
    check("flush_out_valid", {63'b0, bus.out_valid}, 64'h0);
    check("flush_in_ready", {63'b0, bus.in_ready}, 64'h1);
    step(1'b1, 32'h3100, 32'h0800_0c40, 1'b0, 1'b0, 1'b0);
    check("post_flush_out_pc", {32'b0, bus.out_pc}, 64'h3100);
    idle_pop(1);

    // Reset mid-operation with two entries queued.
    step(1'b1, 32'h3200, 32'h3000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3204, 32'h3000_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3208, 32'h3000_0002, 1'b1, 1'b0, 1'b1);
    check("rst2_count", 64'(bus.count), 64'h0);
    check("rst2_in_ready", {63'b0, bus.in_ready}, 64'h1);
    check("rst2_out_valid", {63'b0, bus.out_valid}, 64'h0);
    step(1'b1, 32'h3300, 32'h2408_0005, 1'b0, 1'b0, 1'b0);
    check("rst2_push_pc", {32'b0, bus.out_pc}, 64'h3300);
    check("rst2_push_instr", {32'b0, bus.out_instr}, 64'h2408_0005);
    idle_pop(1);
    check("rst2_drained", 64'(bus.count), 64'h0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty_at_end", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction buffer between the instruction-fetch unit and the decode stage of the 5-stage MIPS pipeline.
- Captures each fetched {PC, Instr} pair into a small FIFO and presents the oldest pair to decode.
- Back-pressures fetch by deasserting in_ready, which is wired to the fetch unit's PC-write enable.
- Discards all buffered instructions on a control-flow redirect (flush).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- AW, 2, pointer width = log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a valid pair this cycle
- in_pc  input  32  PC of fetched instruction
- in_instr  input  32  fetched instruction word
- in_ready  output  1  queue can accept; drives fetch PC-write enable
- out_valid  output  1  oldest entry available to decode
- out_pc  output  32  PC of oldest entry
- out_instr  output  32  oldest instruction word
- out_ready  input  1  decode consumes the presented entry this cycle
- flush  input  1  discard all entries (branch/jump redirect)
- count  output  AW+1  number of valid entries, 0..DEPTH

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Storage: DEPTH x 64-bit array {pc, instr}, write pointer wp, read pointer rp (AW bits each, wrap modulo DEPTH), occupancy register cnt (AW+1 bits).
- Reset, sampled at posedge clk:
  - wp=0, rp=0, cnt=0.
  - Outputs then read: out_valid=0, out_pc=0, out_instr=0, in_ready=1, count=0.
  - Array contents are don't-care.
- Combinational outputs:
  - in_ready = (cnt != DEPTH).
  - out_valid = (cnt != 0).
  - count = cnt.
  - out_pc / out_instr = entry[rp] when out_valid, else 32'h0000_0000. An empty queue therefore presents a nop (instr 0).
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- At posedge, when neither reset nor flush is active:
  - push: entry[wp] <= {in_pc, in_instr}; wp <= wp+1.
  - pop: rp <= rp+1.
  - cnt <= cnt + push - pop.
  - Simultaneous push and pop leave cnt unchanged.
- Latency: a pushed pair appears on out_* no earlier than the cycle after the push edge. There is no same-cycle bypass from in_* to out_*.
- Full: in_ready=0 even if out_ready=1 in the same cycle. No push-through when full; fetch retries next cycle.
- Empty: pop is impossible because out_valid=0; out_ready is ignored.
- Wrap-around: pointers wrap from DEPTH-1 to 0. FIFO order is preserved across the wrap.
- Flush (synchronous):
  - At posedge with flush=1: wp<=0, rp<=0, cnt<=0.
  - Any push or pop in that cycle is discarded.
  - Following cycle: out_valid=0, in_ready=1.
- Priority: reset > flush > push/pop.
- Reset mid-operation: behaves exactly as flush; all entries are lost.
- Unknowns: in_pc and in_instr are ignored when in_valid=0. The array is not written.

Test Plan:
- Reset, then idle -> out_valid=0, out_instr=0, out_pc=0, in_ready=1, count=0.
- Push {0x3000, 0x24080001} with out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, out_instr=0x24080001, count=1. Nothing appears on out_* in the push cycle itself.
- Push 4 pairs (PC 0x3000..0x300C) with out_ready=0 -> count=4, in_ready=0. A 5th in_valid with out_ready=1 is not accepted. After the pop, in_ready=1 and out_pc=0x3004.
- Continuous push+pop for 10 cycles, PCs 0x3000 step 4 -> count stays 1. out_pc sequence is 0x3000, 0x3004, …, in order across pointer wrap.
- Fill 3 entries, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. The next push {0x3100, x} is presented with out_pc=0x3100.
- With 2 entries queued, assert reset for one cycle -> count=0, in_ready=1, out_valid=0. A subsequent push/pop sequence behaves as after initial reset.
